pwm_duty_ctrl: RTL and testbench
================================

PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 SHALL have parameter DB_CNT, default 20000: consecutive stable cycles required to accept a key level change.
REQ-002 SHALL have parameter RAMP_DIV, default 32768: clock cycles per breathe step.
REQ-003 SHALL have parameter STEP, default 1: duty increment/decrement per event.
REQ-004 SHALL have parameter DUTY_INIT, default 1016 (10'h3F8): reset duty.
REQ-005 SHALL have port clk, in, 1: single clock, all logic on posedge.
REQ-006 SHALL have port rst_n, in, 1: asynchronous, active-low reset.
REQ-007 SHALL have port key_up, in, 1: raw button, active-high, asynchronous to clk.
REQ-008 SHALL have port key_dn, in, 1: raw button, active-high, asynchronous to clk.
REQ-009 SHALL have port key_mode, in, 1: raw button, active-high, asynchronous to clk.
REQ-010 SHALL have port frame_start, in, 1: one-cycle pulse from the PWM generator at counter wrap.
REQ-011 SHALL have port duty, out, 10: compare value for the PWM generator (led high while count < duty).
REQ-012 SHALL have port duty_upd, out, 1: one-cycle pulse coincident with each duty change.
REQ-013 SHALL have port mode, out, 2: FSM state (00 MANUAL, 01 BREATHE_UP, 10 BREATHE_DN).

Function
REQ-014 SHALL pass each raw key through a 2-flop synchronizer before any other logic.
REQ-015 SHALL debounce each key: the debounced level changes only after the synchronized input differs from it for DB_CNT consecutive cycles; any mismatch gap restarts the count.
REQ-016 SHALL generate a one-cycle press event on each 0->1 edge of a debounced level; a held key gives exactly one event.
REQ-017 SHALL hold an internal 10-bit target register; duty is a shadow copy of target.
REQ-018 SHALL, in MANUAL, on an up event set target = min(target+STEP, 1023), and on a down event set target = max(target-STEP, 0); the arithmetic is 11-bit with no wrap.
REQ-019 SHALL, in MANUAL, leave target unchanged when up and down events occur in the same cycle.
REQ-020 SHALL, on a mode event, move MANUAL->BREATHE_UP and BREATHE_UP/BREATHE_DN->MANUAL; a mode event overrides any up or down event in the same cycle.
REQ-021 SHALL run the ramp counter 0..RAMP_DIV-1 only in BREATHE states, clear it on entry to BREATHE_UP from MANUAL, and issue a tick on each wrap.
REQ-022 SHALL, in BREATHE_UP on a tick, increment target with saturation and go to BREATHE_DN on the tick where target reaches 1023.
REQ-023 SHALL, in BREATHE_DN on a tick, decrement target with saturation and go to BREATHE_UP on the tick where target reaches 0.
REQ-024 SHALL ignore up and down events in BREATHE states.
REQ-025 SHALL retain the current target when returning to MANUAL.
REQ-026 SHALL load duty from target only in the cycle after frame_start, so duty never changes mid-PWM-period.
REQ-027 SHALL pulse duty_upd in the same cycle duty changes, and SHALL NOT pulse it when target equals duty at frame_start.
REQ-028 SHALL give a latency of 1 cycle from press event to target, then the next frame_start +1 cycle to duty.

Reset
REQ-029 SHALL, while rst_n=0, immediately force duty=DUTY_INIT, target=DUTY_INIT, mode=00, duty_upd=0, debounced levels=0, and all counters and synchronizers to 0, including mid-ramp or mid-debounce.
REQ-030 SHALL resume normal operation on the first clk edge after rst_n deasserts, with no spurious press events.

Verification (DB_CNT=4, RAMP_DIV=8, STEP=8, frame_start every 4 cycles unless stated)
REQ-031 SHALL cover: release reset -> duty=1016, mode=00, duty_upd=0 until a change occurs.
REQ-032 SHALL cover: key_up held 20 cycles -> one event, target=1023 (saturated), duty=1023 after next frame_start, single duty_upd pulse; a 2-cycle key_up glitch -> no change.
REQ-033 SHALL cover: from duty=16, three key_dn presses -> duty 8, 0, 0; no duty_upd on the third press.
REQ-034 SHALL cover: key_mode press -> mode=01, target +8 every 8 cycles, mode=10 on the tick reaching 1023, then a decrement on the next tick.
REQ-035 SHALL cover: key_mode and key_up pressed in the same cycle in MANUAL -> mode=01, target unchanged.
REQ-036 SHALL cover: rst_n pulsed low mid-BREATHE_DN -> duty=1016 and mode=00 asynchronously, with no duty_upd pulse.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// Button-driven PWM duty controller: debounced up/down/mode keys, a manual/breathe FSM,
// and a duty shadow register that only reloads at PWM frame boundaries.
module pwm_duty_ctrl #(
    parameter int          DB_CNT    = 20000,
    parameter int          RAMP_DIV  = 32768,
    parameter int          STEP      = 1,
    parameter logic [9:0]  DUTY_INIT = 10'h3F8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up,
    input  logic       key_dn,
    input  logic       key_mode,
    input  logic       frame_start,
    output logic [9:0] duty,
    output logic       duty_upd,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        MANUAL     = 2'b00,
        BREATHE_UP = 2'b01,
        BREATHE_DN = 2'b10
    } mode_e;

    localparam int              DBW       = $clog2(DB_CNT + 1);
    localparam int              RW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DBW-1:0]  DB_LAST   = DBW'(DB_CNT - 1);
    localparam logic [RW-1:0]   RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [10:0]     STEP_W    = 11'(STEP);

    // Key vector order: [0] up, [1] down, [2] mode.
    logic [2:0]     key_raw;
    logic [2:0]     sync1_q, sync2_q;
    logic [2:0]     db_q, db_prev_q;
    logic [DBW-1:0] db_cnt_q [3];
    logic [2:0]     press_ev;

    assign key_raw = {key_mode, key_dn, key_up};

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press_ev = db_q & ~db_prev_q;

    mode_e          mode_q, mode_d;
    logic [9:0]     target_q, target_d;
    logic [RW-1:0]  ramp_q, ramp_d;
    logic [9:0]     duty_q;
    logic           duty_upd_q;
    logic           tick;
    logic [10:0]    inc_sum;
    logic [9:0]     inc_sat, dec_sat;

    assign inc_sum = {1'b0, target_q} + STEP_W;
    assign inc_sat = (inc_sum > 11'd1023) ? 10'd1023 : inc_sum[9:0];
    assign dec_sat = ({1'b0, target_q} < STEP_W) ? 10'd0 : (target_q - STEP_W[9:0]);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        mode_d   = mode_q;
        target_d = target_q;
        ramp_d   = ramp_q;
        tick     = (mode_q != MANUAL) && (ramp_q == RAMP_LAST);
        case (mode_q)
            MANUAL: begin
                ramp_d = '0;
                if (press_ev[2])                      mode_d   = BREATHE_UP;
                else if (press_ev[0] && !press_ev[1]) target_d = inc_sat;
                else if (press_ev[1] && !press_ev[0]) target_d = dec_sat;
            end
            BREATHE_UP: begin
                ramp_d = tick ? '0 : ramp_q + 1'b1;
                if (press_ev[2]) begin
                    mode_d = MANUAL;
                    ramp_d = '0;
                end else if (tick) begin
                    target_d = inc_sat;
                    if (inc_sat == 10'd1023) mode_d = BREATHE_DN;
                end
            end
            BREATHE_DN: begin
                ramp_d = tick ? '0 : ramp_q + 1'b1;
                if (press_ev[2]) begin
                    mode_d = MANUAL;
                    ramp_d = '0;
                end else if (tick) begin
                    target_d = dec_sat;
                    if (dec_sat == 10'd0) mode_d = BREATHE_UP;
                end
            end
            default: begin
                mode_d = MANUAL;
                ramp_d = '0;
            end
        endcase
    end

    // Duty only reloads at a frame boundary so a PWM period never sees a changing compare value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MANUAL;
            target_q   <= DUTY_INIT;
            ramp_q     <= '0;
            duty_q     <= DUTY_INIT;
            duty_upd_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            target_q <= target_d;
            ramp_q   <= ramp_d;
            if (frame_start) begin
                duty_q     <= target_q;
                duty_upd_q <= (target_q != duty_q);
            end else begin
                duty_upd_q <= 1'b0;
            end
        end
    end

    assign duty     = duty_q;
    assign duty_upd = duty_upd_q;
    assign mode     = mode_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: stimulus queues expected duty values, a monitor
// pops one per duty_upd pulse; direct checks cover reset, mode and saturation points.
module tb_pwm_duty_ctrl;

    logic       clk;
    logic       rst_n;
    logic       key_up, key_dn, key_mode;
    logic       frame_start;
    logic [9:0] duty;
    logic       duty_upd;
    logic [1:0] mode;

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q [$];

    pwm_duty_ctrl #(
        .DB_CNT   (4),
        .RAMP_DIV (8),
        .STEP     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_up      (key_up),
        .key_dn      (key_dn),
        .key_mode    (key_mode),
        .frame_start (frame_start),
        .duty        (duty),
        .duty_upd    (duty_upd),
        .mode        (mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running frame_start: one pulse every 4 cycles.
    initial begin
        int fcnt;
        fcnt        = 0;
        frame_start = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fcnt        = (fcnt + 1) % 4;
            frame_start = (fcnt == 0);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Monitor: every duty_upd pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && duty_upd === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_duty_upd: got duty=%0d expected no update", duty);
                end else begin
                    check("duty_upd_value", int'(duty), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_q(input int n, input int limit, input string name);
        int k;
        k = 0;
        while (exp_q.size() != n && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, exp_q.size(), n);
    endtask

    task automatic wait_mode(input int m, input int limit, input string name);
        int k;
        k = 0;
        while (int'(mode) != m && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, int'(mode), m);
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check({name, "_duty"}, int'(duty), 1016);
        check({name, "_mode"}, int'(mode), 0);
        check({name, "_upd"},  int'(duty_upd), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [2:0] keys);
        {key_mode, key_dn, key_up} = keys;
        repeat (8) @(posedge clk);
        #1;
        {key_mode, key_dn, key_up} = 3'b000;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        key_up   = 1'b0;
        key_dn   = 1'b0;
        key_mode = 1'b0;

        // Reset state, while held and after release.
        repeat (3) @(posedge clk);
        #2;
        check("rst_hold_duty", int'(duty), 1016);
        check("rst_hold_mode", int'(mode), 0);
        check("rst_hold_upd",  int'(duty_upd), 0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_duty", int'(duty), 1016);
        check("post_rst_mode", int'(mode), 0);

        // Two-cycle glitch on key_up is rejected by the debouncer.
        @(posedge clk);
        #1;
        key_up = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        key_up = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_duty", int'(duty), 1016);

        // Long key_up hold: one event, saturates 1016+8 to 1023.
        exp_q.push_back(10'd1023);
        key_up = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        key_up = 1'b0;
        repeat (12) @(posedge clk);
        wait_q(0, 40, "up_hold_drained");
        repeat (12) @(negedge clk);
        check("up_hold_duty", int'(duty), 1023);

        // Mode and up pressed together: mode wins, target stays 1016.
        apply_reset("rst_a");
        repeat (4) @(posedge clk);
        #1;
        key_mode = 1'b1;
        key_up   = 1'b1;
        wait_mode(1, 20, "mode_up_same_mode");
        repeat (4) @(negedge clk);
        check("mode_up_same_duty", int'(duty), 1016);
        apply_reset("rst_b");
        key_mode = 1'b0;
        key_up   = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Down presses from 1016 pass through 16 then 8, 0 and saturate at 0.
        for (int i = 1; i <= 127; i++) exp_q.push_back(10'(1016 - 8 * i));
        for (int i = 0; i < 128; i++) press(3'b010);
        wait_q(0, 40, "dn_drained");
        repeat (8) @(negedge clk);
        check("dn_floor_duty", int'(duty), 0);

        // Breathe: ramp up by 8 per tick, turn at 1023, first decrement to 1015.
        for (int i = 1; i <= 127; i++) exp_q.push_back(10'(8 * i));
        exp_q.push_back(10'd1023);
        exp_q.push_back(10'd1015);
        key_mode = 1'b1;
        wait_mode(1, 20, "breathe_up_mode");
        repeat (2) @(posedge clk);
        #1;
        key_mode = 1'b0;
        wait_q(1, 1500, "breathe_reach_top");
        check("breathe_dn_mode", int'(mode), 2);
        wait_q(0, 40, "breathe_first_dec");

        // Asynchronous reset in the middle of BREATHE_DN.
        apply_reset("rst_mid_dn");
        repeat (20) @(negedge clk);
        check("final_mode", int'(mode), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
